// File: rtl/tpu_result_drain.sv
// ============================================================================
// tpu_result_drain : reads result rows from the results SRAM and serializes
// them lane-group by lane-group onto a valid/ready stream, lane 0 first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tpu_result_drain #(
  parameter int ADDRESSSIZE    = 10,
  parameter int MATRIX_SIZE    = 64,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int LANES_PER_BEAT = 4,
  parameter int WORDSIZE       = PARTIAL_SUM_BW * MATRIX_SIZE
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     start,
  input  logic [ADDRESSSIZE-1:0]                   base_addr,
  input  logic [ADDRESSSIZE:0]                     row_count,
  output logic                                     sram_rd_en,
  output logic [ADDRESSSIZE-1:0]                   sram_rd_addr,
  input  logic [WORDSIZE-1:0]                      sram_rd_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [PARTIAL_SUM_BW*LANES_PER_BEAT-1:0] out_data,
  output logic                                     out_last_beat,
  output logic                                     out_last,
  output logic                                     busy,
  output logic                                     done
);

  localparam int c_beats  = MATRIX_SIZE / LANES_PER_BEAT;
  localparam int c_beat_w = PARTIAL_SUM_BW * LANES_PER_BEAT;
  localparam int c_bidx_w = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam logic [c_bidx_w-1:0]    c_last_beat = c_bidx_w'(c_beats - 1);
  localparam logic [c_bidx_w-1:0]    c_bidx_one  = c_bidx_w'(1);
  localparam logic [ADDRESSSIZE:0]   c_row_one   = (ADDRESSSIZE+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESSSIZE-1:0]  base_q, base_d;
  logic [ADDRESSSIZE:0]    count_q, count_d;
  logic [ADDRESSSIZE:0]    row_idx_q, row_idx_d;
  logic [c_bidx_w-1:0]     beat_idx_q, beat_idx_d;
  logic [WORDSIZE-1:0]     row_q, row_d;

  logic [c_beat_w-1:0]     w_beats [c_beats];
  logic                    w_last_beat;
  logic                    w_last_row;

  genvar g;
  generate
    for (g = 0; g < c_beats; g++) begin : g_beat
      assign w_beats[g] = row_q[g*c_beat_w +: c_beat_w];
    end
  endgenerate

  assign w_last_beat = (beat_idx_q == c_last_beat);
  assign w_last_row  = (row_idx_q == (count_q - c_row_one));
  assign busy        = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      row_idx_q  <= '0;
      beat_idx_q <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      row_idx_q  <= row_idx_d;
      beat_idx_q <= beat_idx_d;
      row_q      <= row_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    count_d       = count_q;
    row_idx_d     = row_idx_q;
    beat_idx_d    = beat_idx_q;
    row_d         = row_q;
    sram_rd_en    = 1'b0;
    sram_rd_addr  = '0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last_beat = 1'b0;
    out_last      = 1'b0;
    done          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (row_count == '0) begin
            state_d = S_FIN;
          end else begin
            base_d    = base_addr;
            count_d   = row_count;
            row_idx_d = '0;
            state_d   = S_READ;
          end
        end
      end
      S_READ: begin
        // Address arithmetic wraps at the SRAM depth.
        sram_rd_en   = 1'b1;
        sram_rd_addr = base_q + row_idx_q[ADDRESSSIZE-1:0];
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        row_d      = sram_rd_data;
        beat_idx_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        out_valid     = 1'b1;
        out_data      = w_beats[beat_idx_q];
        out_last_beat = w_last_beat;
        out_last      = w_last_beat && w_last_row;
        if (out_ready) begin
          if (!w_last_beat) begin
            beat_idx_d = beat_idx_q + c_bidx_one;
          end else if (w_last_row) begin
            state_d = S_FIN;
          end else begin
            row_idx_d = row_idx_q + c_row_one;
            state_d   = S_READ;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_tpu_result_drain.sv
// ============================================================================
// tb_tpu_result_drain : table-driven and scoreboard bench for tpu_result_drain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tpu_result_drain;

  localparam int AW  = 10;
  localparam int MS  = 64;
  localparam int PW  = 24;
  localparam int LPB = 4;
  localparam int WS  = PW * MS;
  localparam int BW  = PW * LPB;
  localparam int NB  = MS / LPB;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   row_count = '0;
  logic          sram_rd_en;
  logic [AW-1:0] sram_rd_addr;
  logic [WS-1:0] sram_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;
  logic          out_last_beat;
  logic          out_last;
  logic          busy;
  logic          done;

  tpu_result_drain #(
    .ADDRESSSIZE(AW), .MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PW), .LANES_PER_BEAT(LPB)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .row_count(row_count),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last_beat(out_last_beat), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Row at address a, lane k holds k ^ ((a ^ 5) << 8); row 5 lane k is k.
  function automatic logic [PW-1:0] lane_val(input int a, input int k);
    int t;
    t = k ^ ((a ^ 5) << 8);
    return t[PW-1:0];
  endfunction

  function automatic logic [WS-1:0] gen_row(input logic [AW-1:0] a);
    logic [WS-1:0] r;
    for (int k = 0; k < MS; k++) r[k*PW +: PW] = lane_val(int'(a), k);
    return r;
  endfunction

  always @(posedge clk) if (sram_rd_en) sram_rd_data <= gen_row(sram_rd_addr);

  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  typedef struct {
    logic [BW-1:0] data;
    logic          lb;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int beats_seen, lb_seen, last_seen, done_seen, busy_cyc, valid_seen;
  int last_xfer_cyc = 0;
  int start_cyc = 0;
  int exp_rows = 0;
  logic          p_stall = 1'b0;
  logic [BW-1:0] p_data;
  logic          p_lb, p_last;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  task automatic mon();
    beat_t e;
    if (!rstn) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("stall_valid", 128'(out_valid), 128'(1'b1));
        chk("stall_data", 128'(out_data), 128'(p_data));
        chk("stall_flags", 128'({out_last_beat, out_last}), 128'({p_lb, p_last}));
      end
      if (out_valid) valid_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("beat_extra");
        else begin
          e = exp_q.pop_front();
          chk("beat_data", 128'(out_data), 128'(e.data));
          chk("beat_flags", 128'({out_last_beat, out_last}), 128'({e.lb, e.last}));
        end
        beats_seen++;
        if (out_last_beat) lb_seen++;
        if (out_last) last_seen++;
        last_xfer_cyc = cyc;
      end
      if (sram_rd_en) begin
        if (addr_q.size() == 0) fail("rd_extra");
        else chk("rd_addr", 128'(sram_rd_addr), 128'(addr_q.pop_front()));
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_seen++;
        chk("done_time", 128'(cyc), 128'(exp_rows > 0 ? last_xfer_cyc + 1 : start_cyc + 1));
      end
      p_stall = out_valid && !out_ready;
      p_data  = out_data;
      p_lb    = out_last_beat;
      p_last  = out_last;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_rd_en"}, 128'(sram_rd_en), 128'(0));
    chk({tag, "_rd_addr"}, 128'(sram_rd_addr), 128'(0));
    chk({tag, "_data"}, 128'(out_data), 128'(0));
    chk({tag, "_flags"}, 128'({out_last_beat, out_last}), 128'(0));
    chk({tag, "_busy_done"}, 128'({busy, done}), 128'(0));
  endtask

  task automatic start_drain(input logic [AW-1:0] base, input int rows);
    beat_t         e;
    logic [AW-1:0] a;
    for (int r = 0; r < rows; r++) begin
      a = base + AW'(r);
      addr_q.push_back(a);
      for (int j = 0; j < NB; j++) begin
        for (int l = 0; l < LPB; l++) e.data[l*PW +: PW] = lane_val(int'(a), j*LPB + l);
        e.lb   = (j == NB - 1);
        e.last = (j == NB - 1) && (r == rows - 1);
        exp_q.push_back(e);
      end
    end
    beats_seen = 0; lb_seen = 0; last_seen = 0; done_seen = 0; busy_cyc = 0; valid_seen = 0;
    exp_rows = rows;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; row_count = (AW+1)'(rows); start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); row_count = (AW+1)'($urandom);
  endtask

  task automatic wait_done(input int budget, output int first_v);
    bit got;
    got = 0;
    first_v = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) got = 1;
    end
    if (!got) fail("done_timeout");
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_beats(input int n);
    bit got;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (beats_seen == n) got = 1;
    end
    if (!got) fail("beat_wait_timeout");
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            rows;
    int            mode;
    int            exp_beats;
    int            exp_lb;
    int            exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic run_all();
    int first_v;
    vecs[0] = '{base: 10'd5,    rows: 1, mode: 0, exp_beats: 16, exp_lb: 1, exp_last: 1};
    vecs[1] = '{base: 10'd0,    rows: 2, mode: 1, exp_beats: 32, exp_lb: 2, exp_last: 1};
    vecs[2] = '{base: 10'd1023, rows: 2, mode: 0, exp_beats: 32, exp_lb: 2, exp_last: 1};
    vecs[3] = '{base: 10'd100,  rows: 0, mode: 0, exp_beats: 0,  exp_lb: 0, exp_last: 0};
    vecs[4] = '{base: 10'd1022, rows: 3, mode: 2, exp_beats: 48, exp_lb: 3, exp_last: 1};

    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    for (int v = 0; v < 5; v++) begin
      ready_mode = vecs[v].mode;
      start_drain(vecs[v].base, vecs[v].rows);
      wait_done(3000, first_v);
      chk($sformatf("v%0d_beats", v), 128'(beats_seen), 128'(vecs[v].exp_beats));
      chk($sformatf("v%0d_last_beats", v), 128'(lb_seen), 128'(vecs[v].exp_lb));
      chk($sformatf("v%0d_last", v), 128'(last_seen), 128'(vecs[v].exp_last));
      chk($sformatf("v%0d_done_cnt", v), 128'(done_seen), 128'(1));
      chk($sformatf("v%0d_sb_empty", v), 128'({exp_q.size(), addr_q.size()}), 128'(0));
      if (vecs[v].rows > 0) begin
        chk($sformatf("v%0d_latency", v), 128'(first_v), 128'(start_cyc + 3));
      end else begin
        chk("zero_no_valid", 128'(valid_seen), 128'(0));
        chk("zero_busy_cycles", 128'(busy_cyc), 128'(1));
      end
      exp_q.delete(); addr_q.delete();
    end

    // start pulsed during beat 7 must be ignored
    ready_mode = 0;
    start_drain(10'd0, 1);
    wait_beats(7);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd9; row_count = 11'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200, first_v);
    repeat (5) @(negedge clk);
    #1;
    chk("busy_start_beats", 128'(beats_seen), 128'(16));
    chk("busy_start_done", 128'(done_seen), 128'(1));
    chk("busy_start_idle", 128'(busy), 128'(0));
    chk("busy_start_sb", 128'({exp_q.size(), addr_q.size()}), 128'(0));
    exp_q.delete(); addr_q.delete();

    // asynchronous reset while beat 4 is presented
    start_drain(10'd0, 1);
    wait_beats(4);
    @(posedge clk); #2;
    chk("pre_reset_valid", 128'(out_valid), 128'(1));
    rstn = 1'b0;
    #1;
    check_zero_outputs("midrst");
    exp_q.delete(); addr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", 128'(done_seen), 128'(0));
    rstn = 1'b1;
    start_drain(10'd0, 1);
    wait_done(200, first_v);
    chk("after_rst_beats", 128'(beats_seen), 128'(16));
    chk("after_rst_done", 128'(done_seen), 128'(1));
    chk("after_rst_latency", 128'(first_v), 128'(start_cyc + 3));
    chk("after_rst_sb", 128'({exp_q.size(), addr_q.size()}), 128'(0));
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon();
      end
      run_all();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tpu_result_drain.md
Name: tpu_result_drain

Overview:
- Reads computed result rows back out of the results SRAM and serializes them onto a narrow valid/ready stream toward the host.
- It is the read side of the results path; the systolic array write path fills the SRAM through its count-driven write port.
- Sits beside the results SRAM and owns its address/read port whenever a drain is in progress.
- Lane 0 of each row goes out first.

Parameters:
- ADDRESSSIZE, 10, results SRAM address width
- MATRIX_SIZE, 64, partial-sum lanes per SRAM row
- PARTIAL_SUM_BW, 24, bits per lane
- LANES_PER_BEAT, 4, lanes per output beat; must divide MATRIX_SIZE
- WORDSIZE, PARTIAL_SUM_BW*MATRIX_SIZE, SRAM row width (derived)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a drain; sampled only in IDLE
- base_addr  in  ADDRESSSIZE  first row address, latched on start
- row_count  in  ADDRESSSIZE+1  number of rows to drain, latched on start
- sram_rd_en  out  1  read strobe to the results SRAM
- sram_rd_addr  out  ADDRESSSIZE  read address
- sram_rd_data  in  WORDSIZE  row data, valid one cycle after sram_rd_en
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- out_data  out  PARTIAL_SUM_BW*LANES_PER_BEAT  beat payload; lowest lane index in the LSBs
- out_last_beat  out  1  last beat of the current row
- out_last  out  1  last beat of the whole drain
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the drain completes

Behaviour:
- Reset (async, rstn=0): state IDLE. All outputs 0, including sram_rd_addr and out_data. Internal counters are cleared.
- Reset mid-drain: the drain is abandoned immediately, no done pulse is produced, and rows not yet sent are dropped.
- States: IDLE, READ, WAIT, SEND, FIN.
- IDLE:
  - start=1 with row_count=0 goes to FIN, so done pulses on the next cycle and no SRAM reads occur.
  - start=1 with row_count>0 latches base_addr and row_count, clears row_idx, and goes to READ.
- READ (1 cycle): sram_rd_en=1, sram_rd_addr=base_addr+row_idx modulo 2^ADDRESSSIZE (wraps silently). Next state WAIT.
- WAIT (1 cycle): at the end of this cycle sram_rd_data is captured into the row register and beat_idx is cleared. Next state SEND.
- Latency: start at edge N gives rd_en during cycle N..N+1, capture at edge N+2, and the first out_valid in the cycle after edge N+2 (3 cycles after start).
- SEND:
  - out_valid=1 and out_data=lanes [beat_idx*LANES_PER_BEAT +: LANES_PER_BEAT] of the row register.
  - out_last_beat=1 when beat_idx = MATRIX_SIZE/LANES_PER_BEAT-1.
  - out_last=1 when out_last_beat=1 and row_idx=row_count-1.
- Handshake:
  - A beat transfers on a cycle where out_valid=1 and out_ready=1.
  - While valid is high and ready is low, out_data, out_last_beat and out_last hold stable and valid stays high.
  - out_valid never depends combinationally on out_ready.
- On transfer of a non-last beat: beat_idx increments.
- On transfer of the last beat of a row:
  - If more rows remain, row_idx increments and the next state is READ. out_valid is low for 2 cycles between rows.
  - If it was the final row, the next state is FIN.
- FIN (1 cycle): done=1, busy=1. Next state IDLE.
- start outside IDLE is ignored; base_addr and row_count are not re-latched.
- sram_rd_en is asserted only in READ. The block never writes the SRAM.
- Payload is raw bits with no sign extension or reordering beyond lane slicing.
- Beats per row = MATRIX_SIZE/LANES_PER_BEAT (16 at defaults). Total beats = row_count*16.

Test Plan:
- Single row: SRAM row 5 lane k = k (lane 0=0 … lane 63=63); base_addr=5, row_count=1, out_ready=1.
  - Expect rd_addr=5.
  - Expect 16 beats; beat 0 = {3,2,1,0}, beat 15 = {63,62,61,60}.
  - out_last and out_last_beat high on beat 15.
  - done pulses the cycle after beat 15 transfers; first valid occurs 3 cycles after start.
- Backpressure: row_count=2; out_ready toggles 1,0,0,1 repeating.
  - out_data stays stable during stalls.
  - 32 beats arrive in order with no duplication.
  - out_last_beat is seen twice and out_last once.
- Address wrap: base_addr=1023, row_count=2.
  - Reads go to addresses 1023 then 0, with the data order matching.
- Zero-length drain: row_count=0.
  - No sram_rd_en and no out_valid; done pulses exactly once, one cycle after start; busy is high for 1 cycle.
- start while busy: pulse start with base_addr=9 during beat 7 of a drain from base 0, row_count=1.
  - Ignored: no extra reads and a single done pulse.
- Reset mid-SEND: drop rstn at beat 4.
  - All outputs go to 0 asynchronously with no done.
  - After release, a new start (base_addr=0, row_count=1) drains normally from beat 0.
